// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first subtractor: diff = a - b with final borrow.
// One shared full-subtractor cell, one bit per clock.
module serial_subtractor #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] diff,
  output logic         borrow
);

  localparam int CW = $clog2(W + 1);
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t        state;
  logic [W-1:0]  sa;
  logic [W-1:0]  sb;
  logic [W-1:0]  sd;
  logic [W-1:0]  sd_nxt;
  logic [CW-1:0] cnt;
  logic          br;
  logic          br_nxt;
  logic          x;
  logic          y;
  logic          d;

  always_comb begin
    x      = sa[0];
    y      = sb[0];
    d      = x ^ y ^ br;
    br_nxt = (~x & y) | (~(x ^ y) & br);
    // New bit enters at the top so bit i settles at i after W shifts
    sd_nxt         = sd >> 1;
    sd_nxt[W-1]    = d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      sa     <= '0;
      sb     <= '0;
      sd     <= '0;
      cnt    <= '0;
      br     <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      diff   <= '0;
      borrow <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            sa    <= a;
            sb    <= b;
            br    <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        RUN: begin
          sa  <= sa >> 1;
          sb  <= sb >> 1;
          sd  <= sd_nxt;
          br  <= br_nxt;
          cnt <= cnt + CW'(1);
          if (cnt == LAST) begin
            state  <= DONE;
            busy   <= 1'b0;
            done   <= 1'b1;
            diff   <= sd_nxt;
            borrow <= br_nxt;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed scoreboard bench for serial_subtractor (W=8 and W=1).
// Expected results are queued at start and popped at done.
module tb_serial_subtractor;

  typedef struct packed {
    logic       b;
    logic [7:0] d;
  } res_t;

  logic       clk;
  logic       rst;
  logic       s8;
  logic [7:0] a8;
  logic [7:0] b8;
  logic       busy8;
  logic       done8;
  logic [7:0] diff8;
  logic       borrow8;
  logic       s1;
  logic [0:0] a1;
  logic [0:0] b1;
  logic       busy1;
  logic       done1;
  logic [0:0] diff1;
  logic       borrow1;

  res_t       q8[$];
  res_t       q1[$];
  logic [7:0] last_d8;
  logic       last_b8;
  int         checks;
  int         failures;

  serial_subtractor #(.W(8)) u8 (
    .clk   (clk),
    .rst   (rst),
    .start (s8),
    .a     (a8),
    .b     (b8),
    .busy  (busy8),
    .done  (done8),
    .diff  (diff8),
    .borrow(borrow8)
  );

  serial_subtractor #(.W(1)) u1 (
    .clk   (clk),
    .rst   (rst),
    .start (s1),
    .a     (a1),
    .b     (b1),
    .busy  (busy1),
    .done  (done1),
    .diff  (diff1),
    .borrow(borrow1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  task automatic launch8(input logic [7:0] a, input logic [7:0] b,
                         input bit keep);
    res_t r;
    a8 = a;
    b8 = b;
    s8 = 1'b1;
    r.d = a - b;
    r.b = (a < b);
    q8.push_back(r);
    tick();
    if (!keep) s8 = 1'b0;
  endtask

  task automatic wait8(input string tag, input int n0);
    int   n;
    int   nb;
    res_t r;
    n  = n0;
    nb = 0;
    while (!done8 && n < 30) begin
      if (busy8) nb++;
      chk({tag, "_hold"}, {23'd0, borrow8, diff8}, {23'd0, last_b8, last_d8});
      tick();
      n++;
    end
    chk({tag, "_done"}, {31'd0, done8}, 32'd1);
    chk({tag, "_lat"}, n, 32'd9);
    chk({tag, "_busycyc"}, nb, 9 - n0);
    chk({tag, "_busy_at_done"}, {31'd0, busy8}, 32'd0);
    chk({tag, "_sbq"}, q8.size(), 32'd1);
    r = (q8.size() > 0) ? q8.pop_front() : '0;
    chk({tag, "_diff"}, {24'd0, diff8}, {24'd0, r.d});
    chk({tag, "_borrow"}, {31'd0, borrow8}, {31'd0, r.b});
    last_d8 = r.d;
    last_b8 = r.b;
  endtask

  task automatic op8(input string tag, input logic [7:0] a,
                     input logic [7:0] b);
    launch8(a, b, 1'b0);
    chk({tag, "_busy"}, {31'd0, busy8}, 32'd1);
    wait8(tag, 1);
    tick();
    chk({tag, "_pulse"}, {31'd0, done8}, 32'd0);
    chk({tag, "_idle"}, {31'd0, busy8}, 32'd0);
  endtask

  initial begin
    int   ndone;
    res_t r;
    checks   = 0;
    failures = 0;
    last_d8  = '0;
    last_b8  = 1'b0;
    rst = 1'b1;
    s8  = 1'b0;
    a8  = '0;
    b8  = '0;
    s1  = 1'b0;
    a1  = '0;
    b1  = '0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_busy", {31'd0, busy8}, 32'd0);
    chk("rst_done", {31'd0, done8}, 32'd0);
    chk("rst_diff", {24'd0, diff8}, 32'd0);
    chk("rst_borrow", {31'd0, borrow8}, 32'd0);
    chk("rst1_out", {29'd0, busy1, done1, diff1, borrow1}, 32'd0);

    op8("sub_5_3", 8'd5, 8'd3);
    op8("sub_3_5", 8'd3, 8'd5);
    op8("sub_0_1", 8'd0, 8'd1);
    op8("sub_ff_ff", 8'hFF, 8'hFF);

    // Starts during RUN must be ignored
    launch8(8'hA5, 8'h3C, 1'b0);
    tick();
    tick();
    s8 = 1'b1;
    a8 = '0;
    b8 = '0;
    tick();
    tick();
    tick();
    s8 = 1'b0;
    wait8("ign_start", 6);
    tick();
    chk("ign_once_done", {31'd0, done8}, 32'd0);
    chk("ign_once_busy", {31'd0, busy8}, 32'd0);

    // Start held high: back-to-back results
    launch8(8'd10, 8'd4, 1'b1);
    wait8("b2b_0", 1);
    launch8(8'd10, 8'd4, 1'b1);
    wait8("b2b_1", 1);
    launch8(8'd10, 8'd4, 1'b1);
    wait8("b2b_2", 1);
    s8 = 1'b0;
    tick();
    chk("b2b_end_done", {31'd0, done8}, 32'd0);
    chk("b2b_end_busy", {31'd0, busy8}, 32'd0);

    // Reset in RUN cycle 4
    launch8(8'd200, 8'd100, 1'b0);
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    void'(q8.pop_back());
    chk("mid_rst_busy", {31'd0, busy8}, 32'd0);
    chk("mid_rst_done", {31'd0, done8}, 32'd0);
    chk("mid_rst_diff", {24'd0, diff8}, 32'd0);
    chk("mid_rst_borrow", {31'd0, borrow8}, 32'd0);
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      if (done8) ndone++;
      tick();
    end
    chk("mid_rst_nodone", ndone, 32'd0);
    last_d8 = '0;
    last_b8 = 1'b0;
    op8("post_rst_1_2", 8'd1, 8'd2);

    // W=1 exhaustive
    for (int i = 0; i < 4; i++) begin
      a1 = i[1];
      b1 = i[0];
      s1 = 1'b1;
      r.d = {7'd0, 1'(a1 - b1)};
      r.b = (a1 < b1);
      q1.push_back(r);
      tick();
      s1 = 1'b0;
      chk("w1_busy", {30'd0, busy1, done1}, 32'd2);
      tick();
      chk("w1_done", {30'd0, busy1, done1}, 32'd1);
      r = (q1.size() > 0) ? q1.pop_front() : '0;
      chk("w1_result", {30'd0, borrow1, diff1}, {30'd0, r.b, r.d[0]});
      tick();
      chk("w1_pulse", {31'd0, done1}, 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
